icap_s6_reg_access: RTL and testbench

- Initiator for the Spartan-6 ICAP port. It turns single-register read and write requests into the 16-bit configuration packet sequence: dummy word, sync, Type-1 header, data, then desync.
- Drives the active-low chip-select and read/write-select inputs of the ICAP wrapper, honours BUSY, and captures readback data from O.
- Sits between the reconfiguration control logic and the ICAP wrapper.

---
 rtl/icap_s6_pkg.sv | 66 ++++++
 rtl/icap_s6_seq_rom.sv | 70 +++++++
 rtl/icap_s6_reg_access.sv | 268 ++++++++++++++++++++++++++
 tb/tb_icap_s6_reg_access.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_s6_pkg.sv
// -----------------------------------------------------------------------------
// icap_s6_pkg
// Shared constants, sequence ids, FSM state codes and helper functions for the
// Spartan-6 ICAP register-access initiator.
//   - Configuration packet words (pre bit-swap values).
//   - Type-1 header field constants and header builders wr_hdr()/rd_hdr().
//   - byte_bitswap16(): reverses bit order inside each byte of a 16-bit word,
//     matching the ICAP's bit ordering on I and O.
// -----------------------------------------------------------------------------
package icap_s6_pkg;

    // Fixed packet words
    localparam logic [15:0] DUMMY      = 16'hFFFF;
    localparam logic [15:0] SYNC0      = 16'hAA99;
    localparam logic [15:0] SYNC1      = 16'h5566;
    localparam logic [15:0] NOOP       = 16'h2000;
    localparam logic [15:0] DESYNC_HDR = 16'h30A1;
    localparam logic [15:0] DESYNC_CMD = 16'h000D;

    // Type-1 header fields: [15:13] type, [12:11] opcode, [10:5] addr, [4:0] word count
    localparam logic [15:0] T1_TYPE    = 16'h2000;
    localparam logic [15:0] T1_OP_RD   = 16'h0800;
    localparam logic [15:0] T1_OP_WR   = 16'h1000;
    localparam logic [15:0] T1_WC_ONE  = 16'h0001;

    // Packet sequences held in the sequence ROM
    typedef enum logic [1:0] {
        SEQ_WR     = 2'd0,
        SEQ_RD_PRE = 2'd1,
        SEQ_DESYNC = 2'd2
    } seq_id_t;

    // Controller states
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_WR_SEQ  = 4'd1;
    localparam logic [3:0] ST_RD_PRE  = 4'd2;
    localparam logic [3:0] ST_RD_GAP  = 4'd3;
    localparam logic [3:0] ST_RD_TURN = 4'd4;
    localparam logic [3:0] ST_RD_WAIT = 4'd5;
    localparam logic [3:0] ST_RD_END  = 4'd6;
    localparam logic [3:0] ST_RD_BACK = 4'd7;
    localparam logic [3:0] ST_DESYNC  = 4'd8;
    localparam logic [3:0] ST_DONE    = 4'd9;

    // Type-1 write header for one word to register addr
    function automatic logic [15:0] wr_hdr(input logic [5:0] addr);
        return T1_TYPE | T1_OP_WR | {5'b00000, addr, 5'b00000} | T1_WC_ONE;
    endfunction

    // Type-1 read header for one word from register addr
    function automatic logic [15:0] rd_hdr(input logic [5:0] addr);
        return T1_TYPE | T1_OP_RD | {5'b00000, addr, 5'b00000} | T1_WC_ONE;
    endfunction

    // Reverse the bit order within each byte
    function automatic logic [15:0] byte_bitswap16(input logic [15:0] w);
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7 - i];
            r[8 + i] = w[15 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_s6_seq_rom.sv
// -----------------------------------------------------------------------------
// icap_s6_seq_rom
// Combinational lookup of (sequence id, word index) to the packet word and a
// flag marking the final word of that sequence. Variable words (headers and
// write data) are supplied by the controller.
// Ports:
//   i_seq     sequence id (SEQ_WR, SEQ_RD_PRE, SEQ_DESYNC)
//   i_idx     word index within the sequence
//   i_wr_hdr  Type-1 write header for the current register
//   i_rd_hdr  Type-1 read header for the current register
//   i_wdata   write data word
//   o_word    packet word (pre bit-swap)
//   o_last    1 when i_idx is the last word of the sequence
// -----------------------------------------------------------------------------
module icap_s6_seq_rom
    import icap_s6_pkg::*;
(
    input  seq_id_t     i_seq,
    input  logic [3:0]  i_idx,
    input  logic [15:0] i_wr_hdr,
    input  logic [15:0] i_rd_hdr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_word,
    output logic        o_last
);

    // Word table for the three packet sequences
    always_comb begin
        o_word = NOOP;
        o_last = 1'b1;
        case (i_seq)
            SEQ_WR: begin
                o_last = (i_idx == 4'd7);
                case (i_idx)
                    4'd0:    o_word = DUMMY;
                    4'd1:    o_word = SYNC0;
                    4'd2:    o_word = SYNC1;
                    4'd3:    o_word = NOOP;
                    4'd4:    o_word = i_wr_hdr;
                    4'd5:    o_word = i_wdata;
                    default: o_word = NOOP;
                endcase
            end
            SEQ_RD_PRE: begin
                o_last = (i_idx == 4'd6);
                case (i_idx)
                    4'd0:    o_word = DUMMY;
                    4'd1:    o_word = SYNC0;
                    4'd2:    o_word = SYNC1;
                    4'd3:    o_word = NOOP;
                    4'd4:    o_word = i_rd_hdr;
                    default: o_word = NOOP;
                endcase
            end
            SEQ_DESYNC: begin
                o_last = (i_idx == 4'd3);
                case (i_idx)
                    4'd0:    o_word = DESYNC_HDR;
                    4'd1:    o_word = DESYNC_CMD;
                    default: o_word = NOOP;
                endcase
            end
            default: begin
                o_word = NOOP;
                o_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/icap_s6_reg_access.sv
// -----------------------------------------------------------------------------
// icap_s6_reg_access
// Single-register read/write initiator for the Spartan-6 ICAP. Each request is
// expanded into dummy/sync, a Type-1 header, the data phase (write word or
// readback) and a desync trailer. All ICAP and response outputs are registered:
// the values driven in a cycle are those of the state the FSM occupies in it.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   req_valid/ready     request handshake (ready only when idle)
//   req_write           1 = write, 0 = read
//   req_addr, req_wdata configuration register address and write data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata, rsp_err  readback data (0 for writes) and read-timeout flag
//   icap_ce_n/write_n/i ICAP chip select, direction, input data
//   icap_o, icap_busy   ICAP output data and BUSY
// -----------------------------------------------------------------------------
module icap_s6_reg_access
    import icap_s6_pkg::*;
#(
    parameter bit          BIT_SWAP   = 1'b1,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [5:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        icap_ce_n,
    output logic        icap_write_n,
    output logic [15:0] icap_i,
    input  logic [15:0] icap_o,
    input  logic        icap_busy
);

    localparam int CW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAT = CW'(RD_LATENCY);
    localparam logic [CW-1:0] C_TMO = CW'(RD_TIMEOUT);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_ZERO = CW'(0);

    logic [3:0]    r_state;
    logic [3:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_write;
    logic [5:0]    r_addr;
    logic [15:0]   r_wdata;
    logic          r_err;
    logic          r_ready;
    logic          r_rsp_valid;
    logic [15:0]   r_rdata;
    logic          r_rsp_err;
    logic          r_ce_n;
    logic          r_write_n;
    logic [15:0]   r_icap_i;

    logic [3:0]    w_state_nxt;
    logic [3:0]    w_idx_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_capture;
    logic          w_timeout;
    logic          w_accept;
    logic          w_issue;
    seq_id_t       w_seq;
    logic [15:0]   w_rom_word;
    logic          w_rom_last;
    logic [15:0]   w_word_sw;
    logic [15:0]   w_rd_sw;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    assign w_word_sw = BIT_SWAP ? byte_bitswap16(w_rom_word) : w_rom_word;
    assign w_rd_sw   = BIT_SWAP ? byte_bitswap16(icap_o) : icap_o;

    // Next state, word index and RD_WAIT counter
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_nxt = req_write ? ST_WR_SEQ : ST_RD_PRE;
                    w_idx_nxt   = 4'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            // Word-issue states: a word is consumed only on a cycle BUSY is low
            ST_WR_SEQ, ST_RD_PRE, ST_DESYNC: begin
                if (icap_busy) begin
                    w_state_nxt = r_state;
                end else if (!r_last) begin
                    w_idx_nxt = r_idx + 4'd1;
                end else begin
                    w_idx_nxt = 4'd0;
                    if (r_state == ST_WR_SEQ) begin
                        w_state_nxt = ST_DESYNC;
                    end else if (r_state == ST_RD_PRE) begin
                        w_state_nxt = ST_RD_GAP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RD_GAP: begin
                w_state_nxt = ST_RD_TURN;
            end
            ST_RD_TURN: begin
                w_state_nxt = ST_RD_WAIT;
                w_cnt_nxt   = C_ZERO;
            end
            // Capture takes priority over timeout on the final counter value
            ST_RD_WAIT: begin
                if ((r_cnt >= C_LAT) && !icap_busy) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_RD_END;
                end else if (r_cnt == C_TMO) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RD_END;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            ST_RD_END: begin
                w_state_nxt = ST_RD_BACK;
            end
            ST_RD_BACK: begin
                w_state_nxt = ST_DESYNC;
                w_idx_nxt   = 4'd0;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // Sequence selection for the word the next cycle will drive
    always_comb begin
        w_seq   = SEQ_DESYNC;
        w_issue = 1'b0;
        case (w_state_nxt)
            ST_WR_SEQ: begin
                w_seq   = SEQ_WR;
                w_issue = 1'b1;
            end
            ST_RD_PRE: begin
                w_seq   = SEQ_RD_PRE;
                w_issue = 1'b1;
            end
            ST_DESYNC: begin
                w_seq   = SEQ_DESYNC;
                w_issue = 1'b1;
            end
            default: begin
                w_seq   = SEQ_DESYNC;
                w_issue = 1'b0;
            end
        endcase
    end

    icap_s6_seq_rom u_rom (
        .i_seq    (w_seq),
        .i_idx    (w_idx_nxt),
        .i_wr_hdr (wr_hdr(r_addr)),
        .i_rd_hdr (rd_hdr(r_addr)),
        .i_wdata  (r_wdata),
        .o_word   (w_rom_word),
        .o_last   (w_rom_last)
    );

    // FSM state, index, counter and last-word flag of the word on icap_i
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= C_ZERO;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_rom_last;
        end
    end

    // Request capture and read-timeout flag
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_write <= 1'b0;
            r_addr  <= 6'd0;
            r_wdata <= 16'h0000;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= 1'b0;
        end else if (w_timeout) begin
            r_err   <= 1'b1;
        end else begin
            r_err   <= r_err;
        end
    end

    // Registered ICAP pins; data lines are parked at zero while deselected
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ce_n    <= 1'b1;
            r_write_n <= 1'b0;
            r_icap_i  <= 16'h0000;
        end else begin
            r_ce_n    <= ~(w_issue | (w_state_nxt == ST_RD_WAIT));
            r_write_n <= (w_state_nxt == ST_RD_TURN) | (w_state_nxt == ST_RD_WAIT) |
                         (w_state_nxt == ST_RD_END);
            r_icap_i  <= w_issue ? w_word_sw : 16'h0000;
        end
    end

    // Handshake and response outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_DONE);
            r_rsp_err   <= (w_state_nxt == ST_DONE) & r_err;
        end
    end

    // Readback data: loaded on capture, zeroed on timeout or write completion
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdata <= 16'h0000;
        end else if (w_capture) begin
            r_rdata <= w_rd_sw;
        end else if (w_timeout) begin
            r_rdata <= 16'h0000;
        end else if ((w_state_nxt == ST_DONE) && r_write) begin
            r_rdata <= 16'h0000;
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign req_ready    = r_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rdata;
    assign rsp_err      = r_rsp_err;
    assign icap_ce_n    = r_ce_n;
    assign icap_write_n = r_write_n;
    assign icap_i       = r_icap_i;

endmodule

// File: tb/tb_icap_s6_reg_access.sv
// -----------------------------------------------------------------------------
// Testbench for icap_s6_reg_access: randomized requests, an ICAP responder with
// planned BUSY stalls and readback timing, and a scoreboard of expected ICAP
// words and responses computed from the packet rules.
// -----------------------------------------------------------------------------
module tb_icap_s6_reg_access;

    localparam bit BSW = 1'b1;
    localparam int LAT = 3;
    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [5:0]  req_addr = 6'd0;
    logic [15:0] req_wdata = 16'h0000;
    logic [15:0] icap_o = 16'h0000;
    logic        icap_busy = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, icap_ce_n, icap_write_n;
    logic [15:0] rsp_rdata, icap_i;

    always #5 CLK = ~CLK;

    icap_s6_reg_access #(.BIT_SWAP(BSW), .RD_LATENCY(LAT), .RD_TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .icap_ce_n(icap_ce_n), .icap_write_n(icap_write_n), .icap_i(icap_i),
        .icap_o(icap_o), .icap_busy(icap_busy)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          at;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] word_q[$];
    rsp_t        rsp_q[$];
    int          stall_plan[12];
    int          ready_at = 0;
    logic [15:0] rd_val = 16'h0000;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] ref_swap(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (BSW) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 8; i++)
                    r[8*b + i] = w[8*b + 7 - i];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ICAP responder: BUSY stalls per word plan, readback after ready_at wait cycles
    int rk = 0, rh = 0, rw = 0;
    always @(negedge CLK) begin
        if (RST || req_ready) begin
            rk = 0; rh = 0; rw = 0;
            icap_busy = 1'($urandom_range(0, 1));
            icap_o = 16'($urandom);
        end else if (!icap_ce_n && !icap_write_n) begin
            rw = 0;
            if (rk < 12 && rh < stall_plan[rk]) begin
                icap_busy = 1'b1; rh++;
            end else begin
                icap_busy = 1'b0; rk++; rh = 0;
            end
            icap_o = 16'($urandom);
        end else if (!icap_ce_n && icap_write_n) begin
            icap_busy = (rw < ready_at);
            icap_o = icap_busy ? 16'($urandom) : rd_val;
            rw++;
        end else begin
            rw = 0;
            icap_busy = 1'($urandom_range(0, 1));
            icap_o = 16'($urandom);
        end
    end

    // Monitor: compare ICAP words, direction changes and responses
    logic prev_ce_n = 1'b1, prev_wn = 1'b0;
    rsp_t mon_e;
    always @(negedge CLK) begin
        #1;
        if (RST) begin
            word_q.delete();
            rsp_q.delete();
            prev_ce_n = 1'b1;
            prev_wn = 1'b0;
        end else begin
            if (!icap_ce_n && !icap_write_n) begin
                if (word_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL icap_extra: word %h driven with none expected (cycle %0d)", icap_i, cyc);
                end else begin
                    chk("icap_word", icap_i, word_q[0]);
                    if (!icap_busy) void'(word_q.pop_front());
                end
            end
            if (icap_write_n != prev_wn)
                chk("write_n_turn_ce_n", {prev_ce_n, icap_ce_n}, 2'b11);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_extra: rsp_valid=1 with no response expected (cycle %0d)", cyc);
                end else begin
                    mon_e = rsp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, mon_e.rdata);
                    chk("rsp_err", rsp_err, mon_e.err);
                    chk("rsp_cycle", cyc, mon_e.at);
                end
            end
            prev_ce_n = icap_ce_n;
            prev_wn = icap_write_n;
        end
    end

    task automatic issue(input logic wr, input logic [5:0] a, input logic [15:0] d,
                         input logic [15:0] rv, input int rdy, input bit rnd,
                         input int sk, input int sl);
        logic [15:0] words[$];
        int to, total, cap, lat;
        rsp_t e;
        to = 0;
        @(negedge CLK);
        while (!req_ready && to < 1000) begin
            @(negedge CLK); to++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL idle_wait: req_ready=%0b after %0d cycles, expected 1", req_ready, to);
            return;
        end
        words = '{16'hFFFF, 16'hAA99, 16'h5566, 16'h2000};
        if (wr) begin
            words.push_back(16'h3000 + 16'(a) * 16'd32 + 16'd1);
            words.push_back(d);
            words.push_back(16'h2000);
            words.push_back(16'h2000);
        end else begin
            words.push_back(16'h2800 + 16'(a) * 16'd32 + 16'd1);
            words.push_back(16'h2000);
            words.push_back(16'h2000);
        end
        words.push_back(16'h30A1);
        words.push_back(16'h000D);
        words.push_back(16'h2000);
        words.push_back(16'h2000);
        total = 0;
        for (int k = 0; k < 12; k++) begin
            if (k >= words.size()) stall_plan[k] = 0;
            else if (rnd) stall_plan[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            else stall_plan[k] = (k == sk) ? sl : 0;
            total += stall_plan[k];
        end
        ready_at = rdy;
        rd_val = rv;
        foreach (words[k]) word_q.push_back(ref_swap(words[k]));
        if (wr) begin
            e.rdata = 16'h0000; e.err = 1'b0;
            lat = 8 + 4 + 1 + total;
        end else begin
            cap = (rdy > LAT) ? rdy : LAT;
            if (cap <= TMO) begin
                e.rdata = ref_swap(rv); e.err = 1'b0;
                lat = 7 + 2 + (cap + 1) + 2 + 4 + 1 + total;
            end else begin
                e.rdata = 16'h0000; e.err = 1'b1;
                lat = 7 + 2 + (TMO + 1) + 2 + 4 + 1 + total;
            end
        end
        e.at = cyc + lat;
        rsp_q.push_back(e);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        // Requests presented while busy must be ignored
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("ready_while_busy", req_ready, 1'b0);
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr = 6'($urandom);
            req_wdata = 16'($urandom);
        end
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge CLK);
        RST = 1'b1; req_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #2;
        chk("rst_ce_n", icap_ce_n, 1'b1);
        chk("rst_write_n", icap_write_n, 1'b0);
        chk("rst_icap_i", icap_i, 16'h0000);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
        chk("rst_rsp_err", rsp_err, 1'b0);
    endtask

    initial begin
        int to;
        reset_pulse();
        // Directed write, no stalls
        issue(1'b1, 6'h18, 16'h1234, 16'h0000, 0, 1'b0, -1, 0);
        // Same write, 4-cycle stall on the header word
        issue(1'b1, 6'h18, 16'h1234, 16'h0000, 0, 1'b0, 4, 4);
        // Reads: data at wait cycle 3, data ready immediately, timeout, edge cases
        issue(1'b0, 6'h13, 16'h0000, 16'hBEEF, 3, 1'b0, -1, 0);
        issue(1'b0, 6'h13, 16'h0000, 16'h0180, 0, 1'b0, -1, 0);
        issue(1'b0, 6'h05, 16'h0000, 16'h1357, 1000, 1'b0, -1, 0);
        issue(1'b0, 6'h3F, 16'h0000, 16'hA5C3, TMO, 1'b0, -1, 0);
        issue(1'b0, 6'h00, 16'h0000, 16'h7E81, TMO + 1, 1'b0, -1, 0);
        issue(1'b0, 6'h21, 16'h0000, 16'h55AA, LAT + 2, 1'b0, 2, 3);
        // Random mix
        for (int n = 0; n < 40; n++) begin
            issue(1'($urandom_range(0, 1)), 6'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 20), 1'b1, -1, 0);
        end
        // Reset in the middle of a write, then idle and recover
        issue(1'b1, 6'h0A, 16'hCAFE, 16'h0000, 0, 1'b0, -1, 0);
        reset_pulse();
        repeat (10) @(negedge CLK);
        issue(1'b1, 6'h2B, 16'h0F0F, 16'h0000, 0, 1'b1, -1, 0);
        to = 0;
        while (rsp_q.size() != 0 && to < 1000) begin
            @(negedge CLK); to++;
        end
        if (rsp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", rsp_q.size());
        end
        repeat (3) @(negedge CLK);
        chk("words_left", word_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
